memory_ctrl: RTL and testbench

Program/data memory for the PicoComputer: the responder end of the CPU memory interface. It services CPU word writes and registered reads, with one-cycle read latency. Before the CPU runs, a streaming boot loader fills the memory through a valid/ready port, and the block holds the CPU in reset until loading completes.

---
 rtl/memory_ctrl.sv | 103 ++++++++++
 tb/tb_memory_ctrl.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/memory_ctrl.sv
// PicoComputer program/data memory: a streaming boot loader fills the array, then the
// CPU is released from reset and gets single-port word access with one-cycle read latency.
module memory_ctrl #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] data,
    output logic [DATA_WIDTH-1:0] out,
    input  logic                  ld_valid,
    input  logic [DATA_WIDTH-1:0] ld_data,
    input  logic                  ld_last,
    output logic                  ld_ready,
    output logic [ADDR_WIDTH:0]   ld_count,
    output logic                  cpu_rst_n
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH:0]   ld_count_q, ld_count_d;
    logic [DATA_WIDTH-1:0] out_q, out_d;
    logic                  cpu_rst_n_q, cpu_rst_n_d;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_waddr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic                  ld_full;

    always_comb begin
        state_d     = state_q;
        ld_count_d  = ld_count_q;
        out_d       = '0;
        cpu_rst_n_d = 1'b0;
        mem_we      = 1'b0;
        mem_waddr   = addr;
        mem_wdata   = data;
        // Writing the top address fills the array, which ends the load regardless of ld_last.
        ld_full     = (ld_count_q[ADDR_WIDTH-1:0] == '1);

        case (state_q)
            IDLE: state_d = LOAD;
            LOAD: begin
                if (ld_valid) begin
                    mem_we     = 1'b1;
                    mem_waddr  = ld_count_q[ADDR_WIDTH-1:0];
                    mem_wdata  = ld_data;
                    ld_count_d = ld_count_q + 1'b1;
                    if (ld_last || ld_full) begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                // Array write lands at the same edge, so this read returns the old word.
                out_d       = mem[addr];
                cpu_rst_n_d = 1'b1;
                mem_we      = we;
            end
            default: state_d = IDLE;
        endcase

        if (!rst_n) begin
            mem_we = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ld_count_q  <= '0;
            out_q       <= '0;
            cpu_rst_n_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ld_count_q  <= ld_count_d;
            out_q       <= out_d;
            cpu_rst_n_q <= cpu_rst_n_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    assign out       = out_q;
    assign ld_ready  = (state_q == LOAD);
    assign ld_count  = ld_count_q;
    assign cpu_rst_n = cpu_rst_n_q;

endmodule

// File: tb/tb_memory_ctrl.sv
// Directed bench for memory_ctrl: boot load, full load, loader stalls, CPU traffic and resets.
module tb_memory_ctrl;

    logic        clk;
    logic        rst_n;
    logic        we;
    logic [5:0]  addr;
    logic [15:0] data;
    logic [15:0] out;
    logic        ld_valid;
    logic [15:0] ld_data;
    logic        ld_last;
    logic        ld_ready;
    logic [6:0]  ld_count;
    logic        cpu_rst_n;

    int n_cmp = 0;
    int n_err = 0;

    memory_ctrl #(.ADDR_WIDTH(6), .DATA_WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .we(we), .addr(addr), .data(data), .out(out),
        .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last),
        .ld_ready(ld_ready), .ld_count(ld_count), .cpu_rst_n(cpu_rst_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish, required finish before time limit");
        $fatal(1);
    end

    // Reset held over two edges; returns at a negedge with rst_n just released.
    task automatic do_reset();
        rst_n = 1'b0; we = 1'b0; ld_valid = 1'b0; ld_last = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One loader beat; returns at the following negedge with ld_valid dropped.
    task automatic load_word(input logic [15:0] d, input logic last);
        ld_valid = 1'b1; ld_data = d; ld_last = last;
        @(negedge clk);
        ld_valid = 1'b0; ld_last = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (out !== 16'h0) begin n_err++; $display("FAIL rst_out: got %h want 0000", out); end
        n_cmp++; if (ld_ready !== 1'b0) begin n_err++; $display("FAIL rst_ld_ready: got %b want 0", ld_ready); end
        n_cmp++; if (ld_count !== 7'd0) begin n_err++; $display("FAIL rst_ld_count: got %0d want 0", ld_count); end
        n_cmp++; if (cpu_rst_n !== 1'b0) begin n_err++; $display("FAIL rst_cpu_rst_n: got %b want 0", cpu_rst_n); end
        @(negedge clk);
        n_cmp++; if (ld_ready !== 1'b1) begin n_err++; $display("FAIL rst_load_entry: got %b want 1", ld_ready); end
        n_cmp++; if (cpu_rst_n !== 1'b0) begin n_err++; $display("FAIL rst_cpu_held: got %b want 0", cpu_rst_n); end
    endtask

    task automatic test_load3();
        do_reset();
        n_cmp++; if (ld_ready !== 1'b0) begin n_err++; $display("FAIL l3_idle_ready: got %b want 0", ld_ready); end
        @(negedge clk);
        n_cmp++; if (ld_ready !== 1'b1) begin n_err++; $display("FAIL l3_load_ready: got %b want 1", ld_ready); end
        load_word(16'h1111, 1'b0);
        load_word(16'h2222, 1'b0);
        n_cmp++; if (ld_count !== 7'd2) begin n_err++; $display("FAIL l3_count2: got %0d want 2", ld_count); end
        n_cmp++; if (out !== 16'h0) begin n_err++; $display("FAIL l3_out_load: got %h want 0000", out); end
        load_word(16'h3333, 1'b1);
        n_cmp++; if (ld_ready !== 1'b0) begin n_err++; $display("FAIL l3_ready_run: got %b want 0", ld_ready); end
        n_cmp++; if (ld_count !== 7'd3) begin n_err++; $display("FAIL l3_count3: got %0d want 3", ld_count); end
        n_cmp++; if (cpu_rst_n !== 1'b0) begin n_err++; $display("FAIL l3_cpu_rst_early: got %b want 0", cpu_rst_n); end
        addr = 6'd0;
        @(negedge clk);
        n_cmp++; if (cpu_rst_n !== 1'b1) begin n_err++; $display("FAIL l3_cpu_release: got %b want 1", cpu_rst_n); end
        n_cmp++; if (out !== 16'h1111) begin n_err++; $display("FAIL l3_rd0: got %h want 1111", out); end
        addr = 6'd1;
        @(negedge clk);
        n_cmp++; if (out !== 16'h2222) begin n_err++; $display("FAIL l3_rd1: got %h want 2222", out); end
        addr = 6'd2;
        @(negedge clk);
        n_cmp++; if (out !== 16'h3333) begin n_err++; $display("FAIL l3_rd2: got %h want 3333", out); end
    endtask

    task automatic test_full();
        do_reset();
        @(negedge clk);
        for (int i = 0; i < 64; i++) begin
            if (i == 63) begin
                n_cmp++; if (ld_count !== 7'd63 || ld_ready !== 1'b1) begin
                    n_err++; $display("FAIL full_pre63: got count %0d ready %b want 63 1", ld_count, ld_ready);
                end
            end
            ld_valid = 1'b1; ld_data = 16'(i); ld_last = 1'b0;
            @(negedge clk);
        end
        n_cmp++; if (ld_count !== 7'd64) begin n_err++; $display("FAIL full_count: got %0d want 64", ld_count); end
        n_cmp++; if (ld_ready !== 1'b0) begin n_err++; $display("FAIL full_ready: got %b want 0", ld_ready); end
        ld_data = 16'hDEAD;
        @(negedge clk);
        @(negedge clk);
        n_cmp++; if (ld_count !== 7'd64 || ld_ready !== 1'b0) begin
            n_err++; $display("FAIL full_65th: got count %0d ready %b want 64 0", ld_count, ld_ready);
        end
        ld_valid = 1'b0;
        addr = 6'd63;
        @(negedge clk);
        n_cmp++; if (out !== 16'd63) begin n_err++; $display("FAIL full_rd63: got %h want 003f", out); end
        addr = 6'd0;
        @(negedge clk);
        n_cmp++; if (out !== 16'd0) begin n_err++; $display("FAIL full_rd0: got %h want 0000", out); end
    endtask

    task automatic test_stalls();
        logic        v    [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        logic        lst  [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        logic [15:0] d    [5] = '{16'h00A0, 16'h0BAD, 16'h0BAD, 16'h00A1, 16'h00A2};
        logic [6:0]  cnt  [5] = '{7'd1, 7'd1, 7'd1, 7'd2, 7'd3};
        logic        rdy  [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        do_reset();
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            ld_valid = v[i]; ld_last = lst[i]; ld_data = d[i];
            @(negedge clk);
            n_cmp++; if (ld_count !== cnt[i] || ld_ready !== rdy[i]) begin
                n_err++; $display("FAIL stall_beat%0d: got count %0d ready %b want %0d %b",
                                  i, ld_count, ld_ready, cnt[i], rdy[i]);
            end
        end
        ld_valid = 1'b0; ld_last = 1'b0;
        addr = 6'd0;
        @(negedge clk);
        n_cmp++; if (out !== 16'h00A0) begin n_err++; $display("FAIL stall_rd0: got %h want 00a0", out); end
        addr = 6'd1;
        @(negedge clk);
        n_cmp++; if (out !== 16'h00A1) begin n_err++; $display("FAIL stall_rd1: got %h want 00a1", out); end
        addr = 6'd2;
        @(negedge clk);
        n_cmp++; if (out !== 16'h00A2) begin n_err++; $display("FAIL stall_rd2: got %h want 00a2", out); end
        addr = 6'd3;
        @(negedge clk);
        n_cmp++; if (out !== 16'h0003) begin n_err++; $display("FAIL stall_rd3: got %h want 0003", out); end
    endtask

    task automatic test_cpu_traffic();
        addr = 6'd5; we = 1'b0;
        @(negedge clk);
        n_cmp++; if (out !== 16'h0005) begin n_err++; $display("FAIL cpu_rd5_old: got %h want 0005", out); end
        we = 1'b1; data = 16'hBEEF;
        @(negedge clk);
        n_cmp++; if (out !== 16'h0005) begin n_err++; $display("FAIL cpu_read_first: got %h want 0005", out); end
        we = 1'b0;
        @(negedge clk);
        n_cmp++; if (out !== 16'hBEEF) begin n_err++; $display("FAIL cpu_rd5_new: got %h want beef", out); end
        // CPU writes to addr 7 during IDLE/LOAD must be dropped.
        do_reset();
        we = 1'b1; addr = 6'd7; data = 16'hFFFF;
        @(negedge clk);
        load_word(16'h1234, 1'b0);
        n_cmp++; if (out !== 16'h0) begin n_err++; $display("FAIL cpu_out_load: got %h want 0000", out); end
        n_cmp++; if (ld_count !== 7'd1) begin n_err++; $display("FAIL cpu_load_count: got %0d want 1", ld_count); end
        load_word(16'h5678, 1'b1);
        we = 1'b0; addr = 6'd0;
        @(negedge clk);
        n_cmp++; if (out !== 16'h1234) begin n_err++; $display("FAIL cpu_rd_loaded: got %h want 1234", out); end
        addr = 6'd7;
        @(negedge clk);
        n_cmp++; if (out !== 16'h0007) begin n_err++; $display("FAIL cpu_load_we_ignored: got %h want 0007", out); end
    endtask

    task automatic test_reset_mid_load();
        do_reset();
        @(negedge clk);
        load_word(16'h5555, 1'b0);
        load_word(16'h6666, 1'b0);
        n_cmp++; if (ld_count !== 7'd2) begin n_err++; $display("FAIL mid_count2: got %0d want 2", ld_count); end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        n_cmp++; if (ld_count !== 7'd0 || ld_ready !== 1'b0 || cpu_rst_n !== 1'b0) begin
            n_err++; $display("FAIL mid_idle: got count %0d ready %b cpu_rst_n %b want 0 0 0",
                              ld_count, ld_ready, cpu_rst_n);
        end
        @(negedge clk);
        n_cmp++; if (ld_ready !== 1'b1) begin n_err++; $display("FAIL mid_reload_ready: got %b want 1", ld_ready); end
        load_word(16'hAAAA, 1'b1);
        n_cmp++; if (ld_count !== 7'd1 || ld_ready !== 1'b0) begin
            n_err++; $display("FAIL mid_reload_run: got count %0d ready %b want 1 0", ld_count, ld_ready);
        end
        addr = 6'd0;
        @(negedge clk);
        n_cmp++; if (out !== 16'hAAAA) begin n_err++; $display("FAIL mid_rd0: got %h want aaaa", out); end
        addr = 6'd1;
        @(negedge clk);
        n_cmp++; if (out !== 16'h6666) begin n_err++; $display("FAIL mid_rd1: got %h want 6666", out); end
    endtask

    task automatic test_reset_in_run();
        n_cmp++; if (cpu_rst_n !== 1'b1) begin n_err++; $display("FAIL run_pre_cpu: got %b want 1", cpu_rst_n); end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        n_cmp++; if (cpu_rst_n !== 1'b0 || out !== 16'h0 || ld_ready !== 1'b0) begin
            n_err++; $display("FAIL run_reset: got cpu_rst_n %b out %h ready %b want 0 0000 0",
                              cpu_rst_n, out, ld_ready);
        end
        @(negedge clk);
        n_cmp++; if (ld_ready !== 1'b1) begin n_err++; $display("FAIL run_reload_ready: got %b want 1", ld_ready); end
        load_word(16'h0F0F, 1'b0);
        load_word(16'hF0F0, 1'b1);
        n_cmp++; if (ld_count !== 7'd2) begin n_err++; $display("FAIL run_reload_count: got %0d want 2", ld_count); end
        addr = 6'd1;
        @(negedge clk);
        n_cmp++; if (out !== 16'hF0F0) begin n_err++; $display("FAIL run_reload_rd1: got %h want f0f0", out); end
        n_cmp++; if (cpu_rst_n !== 1'b1) begin n_err++; $display("FAIL run_reload_cpu: got %b want 1", cpu_rst_n); end
    endtask

    initial begin
        rst_n = 1'b0; we = 1'b0; addr = '0; data = '0;
        ld_valid = 1'b0; ld_data = '0; ld_last = 1'b0;
        test_reset();
        test_load3();
        test_full();
        test_stalls();
        test_cpu_traffic();
        test_reset_mid_load();
        test_reset_in_run();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
